// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
// Bundles the writeback-port signals of wb_port_arbiter.
//   master : pipeline side (drives the ALU/MCU/issue/decode requests,
//            receives mcu_ready, stall and the register-file write)
//   slave  : arbiter side
// Signals:
//   alu_wen/alu_wadd/alu_wdata     ALU writeback request (never back-pressured)
//   mcu_valid/mcu_wadd/mcu_wdata   multi-cycle-unit result, qualified by mcu_ready
//   iss_valid/iss_wadd             multi-cycle op issued this cycle
//   rs1/rs2                        source registers of the instruction in decode
//   stall                          hold decode/issue this cycle
//   wsig/wadd/wdata                registered register-file write port
interface wb_port_arbiter_if;
  logic        alu_wen;
  logic [4:0]  alu_wadd;
  logic [31:0] alu_wdata;
  logic        mcu_valid;
  logic [4:0]  mcu_wadd;
  logic [31:0] mcu_wdata;
  logic        mcu_ready;
  logic        iss_valid;
  logic [4:0]  iss_wadd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        wsig;
  logic [4:0]  wadd;
  logic [31:0] wdata;

  modport master (
    output alu_wen, alu_wadd, alu_wdata,
    output mcu_valid, mcu_wadd, mcu_wdata,
    output iss_valid, iss_wadd, rs1, rs2,
    input  mcu_ready, stall, wsig, wadd, wdata
  );

  modport slave (
    input  alu_wen, alu_wadd, alu_wdata,
    input  mcu_valid, mcu_wadd, mcu_wdata,
    input  iss_valid, iss_wadd, rs1, rs2,
    output mcu_ready, stall, wsig, wadd, wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the ALU and a
// multi-cycle unit (MCU). The ALU always wins; MCU results wait in a small
// FIFO (DEPTH entries) and drain whenever the ALU leaves the port idle. With
// the buffer empty an MCU result can go straight to the port in the cycle it
// is handed over.
// Optional scoreboard (macro WB_ARB_SCOREBOARD_EN): tracks registers whose
// multi-cycle result is still outstanding and raises stall on a hazard.
// Without the macro stall is tied low and the issue/decode inputs are unused.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous reset, active low
//   bus   wb_port_arbiter_if.slave (see interface file for the signal list)
// Parameters:
//   DEPTH number of MCU result buffer entries (>= 1)
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    buf_wadd  [DEPTH];
  logic [31:0]   buf_wdata [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          mcu_hs;
  logic          mcu_keep;
  logic          alu_sel;
  logic          pop;
  logic          bypass;
  logic          push;

  logic          sel_wen;
  logic          sel_mcu;
  logic [4:0]    sel_wadd;
  logic [31:0]   sel_wdata;

  logic          wsig_q;
  logic [4:0]    wadd_q;
  logic [31:0]   wdata_q;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready depends on occupancy only; held low while reset is asserted.
  assign bus.mcu_ready = rst & ~full;

  assign mcu_hs   = bus.mcu_valid & bus.mcu_ready;
  // Results for x0 are accepted but never stored or written.
  assign mcu_keep = mcu_hs & (bus.mcu_wadd != 5'd0);
  assign alu_sel  = bus.alu_wen & (bus.alu_wadd != 5'd0);
  assign pop      = ~alu_sel & ~empty;
  // Bypass only with an empty buffer so MCU results stay in order.
  assign bypass   = ~alu_sel & empty & mcu_keep;
  assign push     = mcu_keep & ~bypass;

  always_comb begin
    sel_wen   = 1'b0;
    sel_mcu   = 1'b0;
    sel_wadd  = 5'd0;
    sel_wdata = 32'd0;
    if (alu_sel) begin
      sel_wen   = 1'b1;
      sel_wadd  = bus.alu_wadd;
      sel_wdata = bus.alu_wdata;
    end else if (pop) begin
      sel_wen   = 1'b1;
      sel_mcu   = 1'b1;
      sel_wadd  = buf_wadd[head];
      sel_wdata = buf_wdata[head];
    end else if (bypass) begin
      sel_wen   = 1'b1;
      sel_mcu   = 1'b1;
      sel_wadd  = bus.mcu_wadd;
      sel_wdata = bus.mcu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wsig_q  <= 1'b0;
      wadd_q  <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      wsig_q <= sel_wen;
      if (sel_wen) begin
        wadd_q  <= sel_wadd;
        wdata_q <= sel_wdata;
      end
    end
  end

  assign bus.wsig  = wsig_q;
  assign bus.wadd  = wadd_q;
  assign bus.wdata = wdata_q;

  // Buffer payload is not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_wadd[tail]  <= bus.mcu_wadd;
      buf_wdata[tail] <= bus.mcu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
      end
      // Push at full cannot happen: mcu_ready is low there.
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        stall_int;

  assign stall_int = rst & (pending[bus.rs1] | pending[bus.rs2] |
                            (bus.iss_valid & pending[bus.iss_wadd]));
  assign bus.stall = stall_int;

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (bus.iss_valid && !stall_int && (bus.iss_wadd != 5'd0)) begin
      set_mask[bus.iss_wadd] = 1'b1;
    end
    // Cleared at the edge that launches the write, so decode sees the
    // hazard gone in the same cycle the write reaches the register file.
    if (sel_mcu) begin
      clr_mask[sel_wadd] = 1'b1;
    end
  end

  // Set is applied after clear so a re-issue to the same register wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 32'd0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{bus.iss_valid, bus.iss_wadd, bus.rs1, bus.rs2};
  assign bus.stall = 1'b0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 DEPTH, 2, number of entries in the multi-cycle-unit result buffer (>=1).
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 alu_wen  in  1  ALU writeback request; never back-pressured.
REQ-005 alu_wadd  in  5  ALU destination register.
REQ-006 alu_wdata  in  32  ALU result.
REQ-007 mcu_valid  in  1  multi-cycle-unit result valid.
REQ-008 mcu_wadd  in  5  multi-cycle-unit destination register.
REQ-009 mcu_wdata  in  32  multi-cycle-unit result.
REQ-010 mcu_ready  out  1  buffer can accept a multi-cycle-unit result.
REQ-011 iss_valid  in  1  multi-cycle op issued this cycle.
REQ-012 iss_wadd  in  5  destination of the issued multi-cycle op.
REQ-013 rs1, rs2  in  5 each  source registers of the instruction in decode.
REQ-014 stall  out  1  hold decode/issue this cycle.
REQ-015 wsig  out  1  register-file write enable.
REQ-016 wadd  out  5  register-file write address.
REQ-017 wdata  out  32  register-file write data.

Function
REQ-018 wsig/wadd/wdata SHALL be registered: a write selected in cycle N appears at outputs in cycle N+1, held for exactly one cycle.
REQ-019 Selection priority each cycle: ALU write (alu_wen=1, alu_wadd!=0) first; else buffer head; else same-cycle MCU handshake (bypass, buffer empty only); else wsig=0.
REQ-020 ALU requests with alu_wadd=0 SHALL be ignored and SHALL NOT consume the port.
REQ-021 MCU handshake = mcu_valid & mcu_ready; accepted result enters buffer tail unless bypassed in the same cycle.
REQ-022 MCU results with mcu_wadd=0 SHALL be accepted and discarded (no buffer entry, no write).
REQ-023 mcu_ready = not full; SHALL be combinational from buffer occupancy only.
REQ-024 Buffer is FIFO; pop and push in the same cycle at full SHALL NOT be allowed (ready already low); pop and push at any other occupancy SHALL keep count constant.
REQ-025 Buffer pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-026 Pending scoreboard: 32 bits, bit 0 constant 0.
REQ-027 iss_valid & !stall & iss_wadd!=0 SHALL set pending[iss_wadd] at next edge.
REQ-028 Emitting an MCU-sourced write to address A SHALL clear pending[A] at the same edge that drives the write.
REQ-029 Simultaneous set and clear of the same bit: set wins.
REQ-030 stall = pending[rs1] | pending[rs2] | (iss_valid & pending[iss_wadd]); combinational; x0 never stalls.
REQ-031 DEPTH consecutive ALU-priority cycles with buffer full SHALL hold mcu_ready=0 with no data loss.

Reset
REQ-032 rst=0 at posedge: wsig=0, wadd=0, wdata=0, buffer count=0, pointers=0, all pending bits=0.
REQ-033 During reset mcu_ready=0 and stall=0; inputs ignored.
REQ-034 Reset mid-operation SHALL discard buffered results and pending state; first accept possible the cycle after rst returns to 1.

Configuration
REQ-035 Macro WB_ARB_SCOREBOARD_EN defined: scoreboard and stall per REQ-026..030.
REQ-036 Macro WB_ARB_SCOREBOARD_EN undefined: no pending storage, stall tied 0, iss_valid/iss_wadd/rs1/rs2 unused; write arbitration unchanged.

Verification
REQ-037 ALU wen, wadd=5, wdata=0x11 with MCU idle -> next cycle wsig=1, wadd=5, wdata=0x11.
REQ-038 Same cycle ALU (wadd=3, 0xA) and MCU (wadd=4, 0xB), buffer empty -> cycle+1 writes r3=0xA, cycle+2 writes r4=0xB, mcu_ready stays 1.
REQ-039 DEPTH=2, ALU writes every cycle, MCU valid every cycle -> two accepts then mcu_ready=0; after ALU stops, buffered results written in order, one per cycle.
REQ-040 iss_valid, iss_wadd=7; next cycle rs1=7 -> stall=1 until MCU write to r7 is driven, stall=0 that same cycle.
REQ-041 ALU wadd=0 and MCU wadd=0 same cycle -> no wsig, buffer count unchanged.
REQ-042 Buffer holding 2 entries and r9 pending, rst=0 for one cycle -> count=0, pending cleared, wsig=0, no stale write afterwards.
